// File: rtl/uart_tx_fifo_if.sv
// Write-side and status bundle of the UART transmit stage.
// The producer uses the master view; uart_tx_fifo uses the slave view.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          busy;
  logic          overflow;
  logic          txd;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, busy, overflow, txd
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, busy, overflow, txd
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter.
// The FIFO absorbs write bursts while the line drains at the baud rate.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [2:0]    bit_q,      bit_d;
  logic [7:0]    shift_q,    shift_d;
  logic          txd_q,      txd_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0] level_q,    level_d;
  logic          full_q,     full_d;
  logic          empty_q,    empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;
  logic baud_tick;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    push       = bus.wr_en && !full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Flags come from the next level so full/empty/level always agree.
    full_d     = (level_d == LVL_FULL);
    empty_d    = (level_d == '0);
    overflow_d = overflow_q | (bus.wr_en & full_q);
  end

  // NOTE: the byte storage has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    baud_tick = (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          cnt_d   = '0;
          state_d = IDLE;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
endmodule
